// File: rtl/ui_pkg.sv
// ui_pkg: definitions shared by the instruction sequencer and its LFSR.
//   state_t      : sequencer FSM states
//   DIR_*        : direction indices (bit positions in key_dir / draw_en)
//   LFSR_TAPS    : feedback taps of the 8-bit Fibonacci LFSR (bits 7,5,4,3)
//   CNT_W        : width of the shared window/gap counter
//   lfsr_next()  : one left-shift step of the LFSR
package ui_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN,
      S_SHOW,
      S_WAIT_KEY,
      S_JUDGE,
      S_GAP,
      S_OVER
   } state_t;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   localparam int unsigned CNT_W = 28;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/instruction_sequencer_lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, shifting left every cycle.
//   clk   : system clock
//   reset : asynchronous active-high reset, loads seed
//   seed  : reset value (must be nonzero)
//   q     : current LFSR value
module lfsr8
   import ui_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= seed;
      else       q <= lfsr_next(q);
   end

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: game-round controller. Picks a random direction and
// NOT flag each round, pulses the matching arrow drawer, times the player's
// response, judges it and keeps score and lives.
//   clk          : system clock
//   reset        : asynchronous active-high reset
//   start        : start/restart request, honoured in IDLE or OVER
//   key_dir      : player keys [0]=UP [1]=DOWN [2]=LEFT [3]=RIGHT
//   draw_en      : one-cycle one-hot drawer enable (SHOW)
//   negate       : NOT flag of the current instruction
//   clear_req    : one-cycle screen-blank request (first GAP cycle)
//   score        : correct answers, saturating at 255
//   lives        : remaining lives
//   round_active : high while waiting for the player's key
//   game_over    : high in OVER
module instruction_sequencer
   import ui_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 150_000_000,
   parameter int unsigned BLANK_CYCLES   = 25_000_000,
   parameter int unsigned LIVES          = 3,
   parameter logic [7:0]  SEED           = 8'hA5
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] key_dir,
   output logic [3:0] draw_en,
   output logic       negate,
   output logic       clear_req,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic       round_active,
   output logic       game_over
);

   state_t           state, state_nx;
   logic [7:0]       lfsr_q;
   logic [3:0]       key_q;
   logic [3:0]       pressed;
   logic [3:0]       resp;
   logic             timed_out;
   logic [1:0]       dir;
   logic [CNT_W-1:0] cnt;
   logic             win_end, gap_end, correct;
   logic             unused_lfsr_bits;

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (SEED),
      .q     (lfsr_q)
   );

   assign unused_lfsr_bits = ^lfsr_q[6:2];

   assign pressed = key_dir & ~key_q;
   assign win_end = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign gap_end = (cnt == CNT_W'(BLANK_CYCLES - 1));
   // XOR with negate flips the sense of the match for NOT instructions.
   assign correct = !timed_out && $onehot(resp) && (resp[dir] ^ negate);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:     if (start) state_nx = S_GEN;
         S_GEN:      state_nx = S_SHOW;
         S_SHOW:     state_nx = S_WAIT_KEY;
         S_WAIT_KEY: if ((pressed != '0) || win_end) state_nx = S_JUDGE;
         S_JUDGE:    state_nx = (!correct && lives == 2'd1) ? S_OVER : S_GAP;
         S_GAP:      if (gap_end) state_nx = S_GEN;
         S_OVER:     if (start) state_nx = S_GEN;
         default:    state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_q     <= '0;
         dir       <= '0;
         negate    <= 1'b0;
         resp      <= '0;
         timed_out <= 1'b0;
         cnt       <= '0;
         score     <= '0;
         lives     <= 2'(LIVES);
      end else begin
         key_q <= key_dir;
         unique case (state)
            S_IDLE, S_OVER: begin
               if (start) begin
                  score <= '0;
                  lives <= 2'(LIVES);
               end
            end
            S_GEN: begin
               dir    <= lfsr_q[1:0];
               negate <= lfsr_q[7];
            end
            S_SHOW: cnt <= '0;
            S_WAIT_KEY: begin
               // Captured every cycle; only the value at the exit edge is judged.
               cnt       <= cnt + CNT_W'(1);
               resp      <= pressed;
               timed_out <= (pressed == '0);
            end
            S_JUDGE: begin
               cnt <= '0;
               if (correct) begin
                  if (score != '1) score <= score + 8'd1;
               end else begin
                  lives <= lives - 2'd1;
               end
            end
            S_GAP:   cnt <= cnt + CNT_W'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      draw_en = '0;
      if (state == S_SHOW) begin
         unique case (dir)
            DIR_UP:    draw_en = 4'b0001;
            DIR_DOWN:  draw_en = 4'b0010;
            DIR_LEFT:  draw_en = 4'b0100;
            DIR_RIGHT: draw_en = 4'b1000;
            default:   draw_en = '0;
         endcase
      end
   end

   assign clear_req    = (state == S_GAP) && (cnt == '0);
   assign round_active = (state == S_WAIT_KEY);
   assign game_over    = (state == S_OVER);

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;
   import ui_pkg::*;

   localparam int unsigned TO = 20;
   localparam int unsigned BL = 5;
   localparam int unsigned LV = 3;
   localparam logic [7:0]  SD = 8'hA5;

   localparam int K_CORRECT = 0;
   localparam int K_WRONG   = 1;
   localparam int K_MULTI   = 2;
   localparam int K_TIMEOUT = 3;
   localparam int K_HOLD    = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [3:0] key_dir = '0;
   logic [3:0] draw_en;
   logic       negate, clear_req, round_active, game_over;
   logic [7:0] score;
   logic [1:0] lives;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_lfsr;
   int         m_score, m_lives;
   bit         m_over;

   always #5 clk = ~clk;

   // Reference LFSR sequence straight from the documented recurrence.
   always @(posedge clk or posedge reset) begin
      if (reset) m_lfsr <= SD;
      else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   instruction_sequencer #(
      .TIMEOUT_CYCLES (TO),
      .BLANK_CYCLES   (BL),
      .LIVES          (LV),
      .SEED           (SD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .key_dir      (key_dir),
      .draw_en      (draw_en),
      .negate       (negate),
      .clear_req    (clear_req),
      .score        (score),
      .lives        (lives),
      .round_active (round_active),
      .game_over    (game_over)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic bit judge(input logic [3:0] k, input int d, input bit n, input bit to);
      if (to) return 1'b0;
      if ($countones(k) != 1) return 1'b0;
      if (n) return (k[d] == 1'b0);
      return (k[d] == 1'b1);
   endfunction

   task automatic start_game;
      start = 1'b1;
      tick();
      start = 1'b0;
      m_score = 0; m_lives = int'(LV); m_over = 1'b0;
      checks++; if (score !== 8'd0) begin errors++; $display("FAIL start_score got %0d exp 0", score); end
      checks++; if (lives !== 2'(LV)) begin errors++; $display("FAIL start_lives got %0d exp %0d", lives, LV); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL start_game_over got %b exp 0", game_over); end
      checks++; if (draw_en !== 4'd0) begin errors++; $display("FAIL start_gen_draw got %b exp 0000", draw_en); end
   endtask

   // Entered while the DUT is in GEN; returns in GEN of the next round, or in OVER.
   task automatic do_round(input int kind, input int delay);
      int         d, a, b, n_wait;
      bit         n, to, ok;
      logic [3:0] one, good, k;
      one = 4'b0001;
      d = int'(m_lfsr[1:0]);
      n = m_lfsr[7];
      if (!n) good = one << d;
      else    good = one << ((d + 1 + int'($urandom % 3)) % 4);
      case (kind)
         K_WRONG: k = n ? (one << d) : (one << ((d + 1 + int'($urandom % 3)) % 4));
         K_MULTI: begin
            a = int'($urandom % 4);
            b = (a + 1 + int'($urandom % 3)) % 4;
            k = (one << a) | (one << b);
         end
         default: k = good;
      endcase
      to = (kind == K_TIMEOUT) || (kind == K_HOLD);
      if (kind == K_HOLD) key_dir = k;
      tick();
      checks++; if (draw_en !== (one << d)) begin errors++; $display("FAIL show_draw_en got %b exp %b", draw_en, one << d); end
      checks++; if (negate !== n) begin errors++; $display("FAIL show_negate got %b exp %b", negate, n); end
      checks++; if (clear_req !== 1'b0) begin errors++; $display("FAIL show_clear got %b exp 0", clear_req); end
      tick();
      checks++; if (round_active !== 1'b1) begin errors++; $display("FAIL wait_active got %b exp 1", round_active); end
      if (!to) begin
         repeat (delay) tick();
         key_dir = k;
         tick();
         key_dir = '0;
         checks++; if (round_active !== 1'b0) begin errors++; $display("FAIL judge_entry got round_active=%b exp 0", round_active); end
      end else begin
         n_wait = 0;
         while (round_active === 1'b1 && n_wait < int'(TO) + 10) begin
            tick();
            n_wait++;
         end
         key_dir = '0;
         checks++; if (n_wait != int'(TO)) begin errors++; $display("FAIL window_len got %0d exp %0d", n_wait, TO); end
      end
      ok = judge(k, d, n, to);
      if (ok) m_score = (m_score < 255) ? m_score + 1 : 255;
      else    m_lives = m_lives - 1;
      if (m_lives == 0) m_over = 1'b1;
      tick();
      checks++; if (score !== 8'(m_score)) begin errors++; $display("FAIL judge_score got %0d exp %0d", score, m_score); end
      checks++; if (lives !== 2'(m_lives)) begin errors++; $display("FAIL judge_lives got %0d exp %0d", lives, m_lives); end
      checks++; if (game_over !== m_over) begin errors++; $display("FAIL judge_game_over got %b exp %b", game_over, m_over); end
      if (m_over) return;
      checks++; if (clear_req !== 1'b1) begin errors++; $display("FAIL gap_clear got %b exp 1", clear_req); end
      repeat (BL) begin
         tick();
         checks++; if (clear_req !== 1'b0 || draw_en !== 4'd0) begin errors++; $display("FAIL gap_quiet got clear=%b draw=%b exp 0/0000", clear_req, draw_en); end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #1;
      checks++; if (draw_en !== 4'd0 || negate !== 1'b0 || clear_req !== 1'b0) begin errors++; $display("FAIL reset_pulses got draw=%b neg=%b clr=%b exp 0", draw_en, negate, clear_req); end
      checks++; if (score !== 8'd0 || lives !== 2'(LV)) begin errors++; $display("FAIL reset_score_lives got %0d/%0d exp 0/%0d", score, lives, LV); end
      checks++; if (round_active !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL reset_flags got %b/%b exp 0/0", round_active, game_over); end
      checks++; if (dut.lfsr_q !== 8'hA5) begin errors++; $display("FAIL reset_lfsr got %h exp a5", dut.lfsr_q); end
      @(posedge clk);
      #1 reset = 1'b0;
      tick();
      checks++; if (dut.lfsr_q !== 8'h4A) begin errors++; $display("FAIL lfsr_step got %h exp 4a", dut.lfsr_q); end
      checks++; if (round_active !== 1'b0 || draw_en !== 4'd0) begin errors++; $display("FAIL idle_hold got act=%b draw=%b exp 0", round_active, draw_en); end
   endtask

   task automatic test_correct;
      start_game();
      do_round(K_CORRECT, 4);
   endtask

   task automatic test_timeout;
      do_round(K_TIMEOUT, 0);
      do_round(K_CORRECT, int'(TO) - 1);
   endtask

   task automatic test_random;
      int r;
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom % 10);
         do_round((r < 6) ? K_CORRECT : (r < 8) ? K_WRONG : K_MULTI, int'($urandom % TO));
         if (m_over) start_game();
      end
   endtask

   task automatic test_hold;
      do_round(K_HOLD, 0);
      if (m_over) start_game();
   endtask

   task automatic test_game_over;
      for (int i = 0; i < 4 && !m_over; i++) do_round(K_WRONG, int'($urandom % 5));
      checks++; if (game_over !== 1'b1 || lives !== 2'd0) begin errors++; $display("FAIL over_state got go=%b lives=%0d exp 1/0", game_over, lives); end
      start_game();
      do_round(K_CORRECT, 1);
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 256; i++) do_round(K_CORRECT, int'($urandom % 3));
      checks++; if (score !== 8'd255) begin errors++; $display("FAIL saturate got %0d exp 255", score); end
   endtask

   task automatic test_async_reset;
      tick();
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      checks++; if (dut.state !== S_IDLE) begin errors++; $display("FAIL areset_state got %0d exp %0d", dut.state, S_IDLE); end
      checks++; if (round_active !== 1'b0 || lives !== 2'(LV) || score !== 8'd0) begin errors++; $display("FAIL areset_outputs got act=%b lives=%0d score=%0d exp 0/%0d/0", round_active, lives, score, LV); end
      checks++; if (draw_en !== 4'd0 || clear_req !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL areset_pulses got draw=%b clr=%b go=%b exp 0", draw_en, clear_req, game_over); end
      #1 reset = 1'b0;
      tick();
      start_game();
      do_round(K_CORRECT, 2);
   endtask

   initial begin
      test_reset();
      test_correct();
      test_timeout();
      test_random();
      test_hold();
      test_game_over();
      test_saturation();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
